// File: rtl/fwd_sel_ctrl.sv
// EX-stage operand forwarding-select controller with load-use stall detection.
// Optional stall_cnt output and counter are enabled with `define FWD_STALL_CNT_EN.
module fwd_sel_ctrl #(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rn,
    input  logic [REG_BITS-1:0] id_rm,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_regwrite,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_regwrite,
    input  logic                flush,
    output logic                stall,
`ifdef FWD_STALL_CNT_EN
    output logic [15:0]         stall_cnt,
`endif
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic                ex_valid
);

    localparam logic [REG_BITS-1:0] ZERO_IDX = REG_BITS'(ZERO_REG);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    logic       load_use_c;
    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;
    logic       ex_valid_nxt;

    // Youngest producer wins; a load in EX has no ALU result to forward yet.
    function automatic logic [1:0] pick_sel(
        input logic [REG_BITS-1:0] src,
        input logic [REG_BITS-1:0] e_rd,
        input logic                e_alu_wr,
        input logic [REG_BITS-1:0] m_rd,
        input logic                m_wr,
        input logic [REG_BITS-1:0] w_rd,
        input logic                w_wr
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src == ZERO_IDX)                sel = SEL_RF;
        else if (e_alu_wr && (e_rd == src)) sel = SEL_MEM;
        else if (m_wr && (m_rd == src))     sel = SEL_WB;
        else if (w_wr && (w_rd == src))     sel = SEL_HOLD;
        return sel;
    endfunction

    assign load_use_c = id_valid && ex_regwrite && ex_memread && (ex_rd != ZERO_IDX)
                        && ((ex_rd == id_rn) || (ex_rd == id_rm));

    // Flush overrides the hazard so a killed instruction never stalls the front end.
    assign stall = load_use_c && !flush;

    always_comb begin
        sel_a_nxt    = SEL_RF;
        sel_b_nxt    = SEL_RF;
        ex_valid_nxt = 1'b0;
        if (!flush && !stall && id_valid) begin
            sel_a_nxt    = pick_sel(id_rn, ex_rd, ex_regwrite && !ex_memread,
                                    mem_rd, mem_regwrite, wb_rd, wb_regwrite);
            sel_b_nxt    = pick_sel(id_rm, ex_rd, ex_regwrite && !ex_memread,
                                    mem_rd, mem_regwrite, wb_rd, wb_regwrite);
            ex_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_a    <= SEL_RF;
            sel_b    <= SEL_RF;
            ex_valid <= 1'b0;
        end else begin
            sel_a    <= sel_a_nxt;
            sel_b    <= sel_b_nxt;
            ex_valid <= ex_valid_nxt;
        end
    end

`ifdef FWD_STALL_CNT_EN
    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'h0000;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Randomized and directed self-checking bench for fwd_sel_ctrl.
module tb_fwd_sel_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, flush;
    logic       stall;
    logic [1:0] sel_a, sel_b;
    logic       ex_valid;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    fwd_sel_ctrl #(.REG_BITS(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .flush(flush), .stall(stall),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .sel_a(sel_a), .sel_b(sel_b), .ex_valid(ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: scan producers youngest to oldest, first writer of src decides.
    function automatic logic [1:0] model_sel(input int src);
        int  rd [3];
        bit  wr [3];
        rd[0] = int'(ex_rd);  wr[0] = ex_regwrite && !ex_memread;
        rd[1] = int'(mem_rd); wr[1] = mem_regwrite;
        rd[2] = int'(wb_rd);  wr[2] = wb_regwrite;
        if (src == 31) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (wr[k] && rd[k] == src) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        if (flush || !id_valid || !ex_regwrite || !ex_memread || ex_rd == 5'd31) return 1'b0;
        return (ex_rd == id_rn) || (ex_rd == id_rm);
    endfunction

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rn = 0; id_rm = 0;
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0; flush = 0;
    endtask

    // Inputs already applied after a negedge: check stall, clock, check registers.
    task automatic cycle_check(input string tag);
        bit         es;
        logic [1:0] ea, eb;
        bit         ev;
        #1;
        es = model_stall();
        ev = id_valid && !flush && !es;
        ea = ev ? model_sel(int'(id_rn)) : 2'd0;
        eb = ev ? model_sel(int'(id_rm)) : 2'd0;
        check({tag, ".stall"}, 16'(stall), 16'(es));
        @(posedge clk); #1;
        check({tag, ".sel_a"}, 16'(sel_a), 16'(ea));
        check({tag, ".sel_b"}, 16'(sel_b), 16'(eb));
        check({tag, ".ex_valid"}, 16'(ex_valid), 16'(ev));
    endtask

    task automatic load_use_stall();
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rn = 5'd7; id_rm = 5'd9;
        ex_rd = 5'd9; ex_regwrite = 1; ex_memread = 1;
        cycle_check("cnt_stall");
        @(negedge clk);
        clear_inputs();
        cycle_check("cnt_gap");
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.sel_a", 16'(sel_a), 16'd0);
        check("rst.sel_b", 16'(sel_b), 16'd0);
        check("rst.ex_valid", 16'(ex_valid), 16'd0);
        check("rst.stall", 16'(stall), 16'd0);
`ifdef FWD_STALL_CNT_EN
        check("rst.stall_cnt", stall_cnt, 16'd0);
`endif
        @(negedge clk);
        reset = 0;

        // EX ALU result beats an older MEM producer of the same register.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rn = 5'd3; id_rm = 5'd4;
        ex_rd = 5'd3; ex_regwrite = 1; mem_rd = 5'd3; mem_regwrite = 1;
        cycle_check("prio");
        check("prio.sel_a_const", 16'(sel_a), 16'd1);
        check("prio.sel_b_const", 16'(sel_b), 16'd0);

        // Asynchronous reset mid-cycle clears registered selects at once.
        #2 reset = 1;
        #1;
        check("async_rst.sel_a", 16'(sel_a), 16'd0);
        check("async_rst.ex_valid", 16'(ex_valid), 16'd0);
        @(negedge clk);
        reset = 0;

        // Load-use: stall and bubble, then resolve from MEM next cycle.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rn = 5'd1; id_rm = 5'd5;
        ex_rd = 5'd5; ex_regwrite = 1; ex_memread = 1;
        cycle_check("lu1");
        check("lu1.ex_valid_const", 16'(ex_valid), 16'd0);
        @(negedge clk);
        ex_rd = 5'd0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 5'd5; mem_regwrite = 1;
        cycle_check("lu2");
        check("lu2.sel_b_const", 16'(sel_b), 16'd2);

        // Zero register is never forwarded.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rn = 5'd31; id_rm = 5'd31;
        ex_rd = 5'd31; ex_regwrite = 1; ex_memread = 1;
        cycle_check("zero");

        // Flush wins over a load-use hazard.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rn = 5'd6; id_rm = 5'd6;
        ex_rd = 5'd6; ex_regwrite = 1; ex_memread = 1; flush = 1;
        cycle_check("flush");

        // Same register on both operands, WB holding-register case.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_rn = 5'd2; id_rm = 5'd2; wb_rd = 5'd2; wb_regwrite = 1;
        cycle_check("same_reg");
        check("same_reg.sel_b_const", 16'(sel_b), 16'd3);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            id_valid     = ($urandom_range(0, 7) != 0);
            id_rn        = rnd_reg();
            id_rm        = rnd_reg();
            ex_rd        = rnd_reg();
            ex_regwrite  = 1'($urandom);
            ex_memread   = 1'($urandom);
            mem_rd       = rnd_reg();
            mem_regwrite = 1'($urandom);
            wb_rd        = rnd_reg();
            wb_regwrite  = 1'($urandom);
            flush        = ($urandom_range(0, 7) == 0);
            cycle_check("rand");
        end

`ifdef FWD_STALL_CNT_EN
        @(negedge clk);
        clear_inputs();
        reset = 1;
        #1 reset = 0;
        for (int i = 0; i < 3; i++) load_use_stall();
        check("cnt.three", stall_cnt, 16'd3);
        @(negedge clk);
        force dut.stall_cnt = 16'hFFFF;
        #1 release dut.stall_cnt;
        load_use_stall();
        check("cnt.sat", stall_cnt, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_sel_ctrl.md
# fwd_sel_ctrl

Forwarding-select controller for the pipelined datapath's EX-stage operand muxes. It evaluates the ID-stage source registers against destinations of instructions further down the pipe. It registers a 2-bit select per operand into the ID/EX boundary, driving the s1/s0 inputs of the 4:1 operand mux banks. It also detects load-use hazards, stalls ID for one cycle, and inserts a bubble into EX.

## Interface
- REG_BITS, 5, register index width
- ZERO_REG, 31, index of the hard-wired zero register; never forwarded
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- id_valid  input  1  ID stage holds a real instruction
- id_rn, id_rm  input  REG_BITS  ID-stage source registers (operand A, B)
- ex_rd  input  REG_BITS  destination of instruction currently in EX
- ex_regwrite, ex_memread  input  1  EX instruction writes a register / is a load
- mem_rd  input  REG_BITS  destination of instruction in MEM
- mem_regwrite  input  1  MEM instruction writes a register
- wb_rd  input  REG_BITS  destination of instruction in WB
- wb_regwrite  input  1  WB instruction writes a register
- flush  input  1  branch redirect; kills the ID instruction
- stall  output  1  hold PC and IF/ID this cycle (combinational)
- sel_a, sel_b  output  2  registered mux selects for EX operand A/B; bit1→s1, bit0→s0
- ex_valid  output  1  registered; EX holds a real (non-bubble) instruction

## Operation
- Select encoding: 00 register file, 01 MEM-stage ALU result, 10 WB-stage write data, 11 write-back holding register (value committed last cycle).
- Per operand src (rn→sel_a, rm→sel_b), next select:
  - src == ZERO_REG → 00
  - ex_regwrite & !ex_memread & ex_rd==src → 01
  - else mem_regwrite & mem_rd==src → 10
  - else wb_regwrite & wb_rd==src → 11
  - else 00
- Priority strictly 01 > 10 > 11 > 00 (youngest producer wins).
- Load-use hazard: id_valid & ex_regwrite & ex_memread & ex_rd!=ZERO_REG & (ex_rd==id_rn | ex_rd==id_rm) → stall=1.
- Register update each cycle, first match wins:
  - flush: sel_a=sel_b=00, ex_valid=0
  - stall: bubble, sel_a=sel_b=00, ex_valid=0
  - !id_valid: sel 00, ex_valid=0
  - else: computed selects, ex_valid=1
- On the cycle after a stall, the load sits in MEM, so the same ID instruction resolves to 10.

## Timing
- Reset values: sel_a=00, sel_b=00, ex_valid=0, stall=0 (all inputs low), stall counter 0.
- stall: combinational, same cycle as ID inputs; asserted at most one consecutive cycle per load (second cycle the hazard clears by construction).
- sel_a/sel_b/ex_valid: 1-cycle latency, valid for the whole EX cycle following the ID cycle.
- flush & hazard in same cycle: flush wins, stall=0.
- reset mid-stall: outputs return to reset values asynchronously; stall re-evaluates from inputs after release.
- Both operands naming the same register: both selects identical.

## Configuration
- FWD_STALL_CNT_EN defined: adds output stall_cnt [15:0]. It increments on every cycle with stall=1 and reset=0, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset asserted mid-cycle with sel_a=01 → sel_a, sel_b=00 and ex_valid=0 immediately, before next clk edge.
- ex_rd=3, ex_regwrite=1, mem_rd=3, mem_regwrite=1, id_rn=3, id_rm=4 → after one edge sel_a=01, sel_b=00, ex_valid=1.
- Load ex_rd=5, ex_memread=1, id_rm=5 → stall=1 that cycle, next edge sel_b=00/ex_valid=0; next cycle with mem_rd=5 → sel_b=10, ex_valid=1.
- id_rn=31 with ex_rd=31, ex_regwrite=1 → sel_a=00, no stall.
- Load-use hazard plus flush=1 → stall=0, next edge ex_valid=0, selects 00.
- With FWD_STALL_CNT_EN, 3 separate load-use stalls → stall_cnt=3; forced 16'hFFFF plus one stall → remains 16'hFFFF.
